rca_multicycle_ctrl: RTL and testbench
======================================

Name: rca_multicycle_ctrl

Overview:
- Issue/capture controller wrapped around the 32-bit ripple-carry adder.
- Registers one operand set from a valid/ready source and holds it stable on the adder inputs for a fixed settle window, so the ripple chain is a declared multicycle path.
- Captures sum, carry-out and status flags into output registers, then presents them on a valid/ready result interface.

Parameters:
- WIDTH, 32, operand/sum width; must match the attached adder.
- SETTLE_CYCLES, 2, cycles the adder inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  source has an operand set.
- in_ready  out  1  block accepts an operand set this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry in.
- add_a  out  WIDTH  registered A to adder.
- add_b  out  WIDTH  registered B to adder.
- add_cin  out  1  registered carry to adder.
- add_s  in  WIDTH  adder sum (combinational from add_*).
- add_cout  in  1  adder carry out.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  sink consumes result.
- out_sum  out  WIDTH  captured sum.
- out_cout  out  1  captured carry out.
- out_zero  out  1  captured sum == 0.
- out_ovf  out  1  signed overflow: add_a[MSB]==add_b[MSB] and add_s[MSB]!=add_a[MSB].
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, counter=0.
  - add_a=0, add_b=0, add_cin=0.
  - out_sum=0, out_cout=0, out_zero=0, out_ovf=0.
  - out_valid=0, busy=0.
  - in_ready is combinational and reads 1 immediately after reset.
  - Reset mid-operation discards the in-flight operation and any unconsumed result.
- State IDLE:
  - in_ready=1.
  - Handshake at edge E (in_valid && in_ready): load add_a/add_b/add_cin from inputs, counter=SETTLE_CYCLES-1, state→SETTLE.
- State SETTLE:
  - in_ready=0, and add_* are held constant.
  - Each edge with counter!=0: counter decrements.
  - Edge with counter==0: capture add_s/add_cout and flags into out_* registers, state→DONE.
  - Capture occurs at edge E+SETTLE_CYCLES; out_valid is visible from that edge (latency SETTLE_CYCLES cycles accept→valid).
- State DONE:
  - out_valid=1; out_* held stable until consumed.
  - in_ready = out_ready (combinational).
  - out_ready=0: remain in DONE; in_ready=0.
  - out_ready=1 and in_valid=0: state→IDLE, out_valid falls.
  - out_ready=1 and in_valid=1 at the same edge: result consumed and new operands loaded in that edge, state→SETTLE directly (back-to-back, no IDLE bubble).
- Outputs in every state:
  - add_* outputs change only on an accept edge.
  - out_* change only on a capture edge or at reset.
- Throughput: one result per SETTLE_CYCLES+1 cycles with a continuously ready sink and continuously valid source.
- Arithmetic:
  - No arithmetic is done in the block except the flags.
  - out_zero is computed on the WIDTH-bit sum only; out_cout is excluded.
  - Wrap-around is delegated to the adder; out_cout/out_ovf report it.
- Illegal SETTLE_CYCLES (0 or >15) is caught by an elaboration-time assertion.

Optional Feature:
- Macro RCA_CTRL_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled with the operands.
  - When in_sub=1 at accept: add_b loads ~in_b, add_cin loads 1, and in_cin is ignored.
  - out_ovf uses the effective (inverted) add_b.
  - out_cout is then the not-borrow.
- Not defined: port absent; add_b=in_b, add_cin=in_cin always.

Decomposition:
- Package rca_ctrl_pkg:
  - WIDTH default constant.
  - SETTLE_MAX=15.
  - State enum ctrl_state_t {IDLE, SETTLE, DONE}.
  - Counter width constant (4 bits).
- One sub-module, rca_flags: purely combinational; takes the sum MSB, add_a MSB, add_b MSB and the sum; produces zero and ovf.
- Counter and FSM stay in the top module.

Test Plan:
- Reset then single add: A=0x0000_0005, B=0x0000_0003, cin=0 accepted at edge 0 → out_valid at edge 2 (SETTLE_CYCLES=2); sum=0x8, cout=0, zero=0, ovf=0.
- Wrap: A=0xFFFF_FFFF, B=0x0000_0001, cin=0 → sum=0x0, cout=1, zero=1, ovf=0.
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001 → sum=0x8000_0000, cout=0, ovf=1. Also A=0x8000_0000, B=0x8000_0000 → sum=0, cout=1, zero=1, ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles: out_* stable, in_ready=0.
  - Then assert out_ready with in_valid (A=1, B=1): result consumed and new op accepted in the same edge; next out_valid 2 cycles later, sum=0x2.
- Reset mid-SETTLE: assert rst_n=0 one cycle after accept → next edge all outputs 0, state IDLE, no out_valid ever produced for that op.
- With RCA_CTRL_SUB_EN: A=0x0000_0003, B=0x0000_0005, in_sub=1, in_cin=0 → sum=0xFFFF_FFFE, cout=0; A=5, B=3, in_sub=1 → sum=0x2, cout=1.

Source files
------------

// File: rtl/rca_ctrl_pkg.sv
// Shared constants and state type for the ripple-carry adder issue/capture controller.
package rca_ctrl_pkg;

    localparam int unsigned RCA_WIDTH  = 32;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rca_flags.sv
// Combinational status flags for a captured adder result: zero and signed overflow.
module rca_flags
    import rca_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH
) (
    input  logic             s_msb,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH-1:0] sum,
    output logic             zero,
    output logic             ovf
);

    assign zero = (sum == '0);
    // Same-sign operands producing an opposite-sign result.
    assign ovf  = (a_msb == b_msb) && (s_msb != a_msb);

endmodule

// File: rtl/rca_multicycle_ctrl.sv
// Holds operands stable on an external ripple-carry adder for SETTLE_CYCLES, then captures
// the result. Optional subtract support is enabled with the RCA_CTRL_SUB_EN macro.
module rca_multicycle_ctrl
    import rca_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = RCA_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef RCA_CTRL_SUB_EN
    input  logic             in_sub,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("rca_multicycle_ctrl: SETTLE_CYCLES must be in 1..%0d", SETTLE_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, capture;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic             flag_zero, flag_ovf;

`ifdef RCA_CTRL_SUB_EN
    // Subtract as A + ~B + 1; carry-out then reads as not-borrow.
    assign eff_b   = in_sub ? ~in_b : in_b;
    assign eff_cin = in_sub ? 1'b1 : in_cin;
`else
    assign eff_b   = in_b;
    assign eff_cin = in_cin;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rca_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .s_msb (add_s[WIDTH-1]),
        .a_msb (add_a[WIDTH-1]),
        .b_msb (add_b[WIDTH-1]),
        .sum   (add_s),
        .zero  (flag_zero),
        .ovf   (flag_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                add_a   <= in_a;
                add_b   <= eff_b;
                add_cin <= eff_cin;
            end
            if (capture) begin
                out_sum  <= add_s;
                out_cout <= add_cout;
                out_zero <= flag_zero;
                out_ovf  <= flag_ovf;
            end
        end
    end

endmodule

// File: tb/tb_rca_multicycle_ctrl.sv
// Directed bench for rca_multicycle_ctrl with a behavioural adder on the add_* interface.
module tb_rca_multicycle_ctrl;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_cin;
    logic [W-1:0]  in_a, in_b;
    logic          in_sub;
    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_cin, add_cout;
    logic          out_valid, out_ready, out_cout, out_zero, out_ovf, busy;
    logic [W-1:0]  out_sum;
    logic [W:0]    full_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign full_sum         = 33'(add_a) + 33'(add_b) + 33'(add_cin);
    assign {add_cout, add_s} = full_sum;

    rca_multicycle_ctrl #(
        .WIDTH         (W),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef RCA_CTRL_SUB_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, check settle timing, check result, then consume it.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] e_sum, input logic e_cout,
                         input logic e_zero, input logic e_ovf);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".add_a"}, 64'(add_a), 64'(a));
        step();
        chk({tag, ".early_valid"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".sum"}, 64'(out_sum), 64'(e_sum));
        chk({tag, ".cout"}, 64'(out_cout), 64'(e_cout));
        chk({tag, ".zero"}, 64'(out_zero), 64'(e_zero));
        chk({tag, ".ovf"}, 64'(out_ovf), 64'(e_ovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.add_a", 64'(add_a), 64'd0);
        chk("rst.add_b", 64'(add_b), 64'd0);
        chk("rst.out_sum", 64'(out_sum), 64'd0);
        chk("rst.flags", 64'({out_cout, out_zero, out_ovf, add_cin}), 64'd0);

        do_op("add5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 0, 0, 0);
        do_op("cin", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 0, 0, 0);
        do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 1, 0);
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 0, 1);
        do_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1, 1, 1);

        // Backpressure: result 2+3 held while the sink stalls.
        in_a = 32'd2; in_b = 32'd3; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp.valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_sum", 64'(out_sum), 64'd5);
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.hold_valid", 64'(out_valid), 64'd1);
        end
        // Back-to-back: consume and accept 1+1 on the same edge.
        in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b.valid_drop", 64'(out_valid), 64'd0);
        chk("b2b.busy", 64'(busy), 64'd1);
        chk("b2b.add_a", 64'(add_a), 64'd1);
        step();
        chk("b2b.early", 64'(out_valid), 64'd0);
        step();
        chk("b2b.valid", 64'(out_valid), 64'd1);
        chk("b2b.sum", 64'(out_sum), 64'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset one cycle after accept drops the operation.
        in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst.busy", 64'(busy), 64'd0);
        chk("mid_rst.add_a", 64'(add_a), 64'd0);
        chk("mid_rst.out_sum", 64'(out_sum), 64'd0);
        chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst.no_valid", 64'(out_valid), 64'd0);
        end

`ifdef RCA_CTRL_SUB_EN
        do_op("sub3_5", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        chk("sub3_5.add_b", 64'(add_b), 64'hFFFF_FFFA);
        chk("sub3_5.add_cin", 64'(add_cin), 64'd1);
        do_op("sub5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
